imem_program_loader: RTL and testbench

//   Loads a program image into instruction_memory through its debug port before the core runs.

---
 rtl/imem_program_loader.sv | 256 +++++++++++++++++++++++++
 tb/tb_imem_program_loader.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// imem_program_loader: streams a program image into instruction memory
// through its debug port, optionally reads it back and compares checksums,
// and holds the core in reset until the image is in place.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   start, abort            control pulses (abort has priority over start)
//   base_addr, word_count   image placement and length, latched on start
//   verify_en               read back and compare checksums after loading
//   s_valid/s_data/s_ready  host word stream, one word per cycle max
//   dbg_en/we/addr/wdata    instruction memory debug port requests
//   dbg_rdata               debug read data, one cycle after the request
//   core_hold               keeps the processor in reset while 1
//   busy, done, error       status; done/error held until the next start
//   err_code                0 none, 1 bad count, 2 verify mismatch, 3 timeout
//   load_count              words accepted in the current load
module imem_program_loader #(
    parameter int          CNT_W         = 16,
    parameter int unsigned MAX_WORDS     = 1024,
    parameter int unsigned TIMEOUT       = 0,
    parameter bit          HOLD_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic             verify_en,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    output logic             s_ready,
    output logic             dbg_en,
    output logic             dbg_we,
    output logic [31:0]      dbg_addr,
    output logic [31:0]      dbg_wdata,
    input  logic [31:0]      dbg_rdata,
    output logic             core_hold,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] load_count
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_CHECK = 3'd3;
    localparam logic [2:0] S_COMPARE  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;
    localparam logic [2:0] S_ERROR    = 3'd6;

    localparam logic [1:0] E_NONE    = 2'd0;
    localparam logic [1:0] E_COUNT   = 2'd1;
    localparam logic [1:0] E_VERIFY  = 2'd2;
    localparam logic [1:0] E_TIMEOUT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             verify_q, verify_d;
    logic [CNT_W-1:0] load_count_q, load_count_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic [31:0]      wsum_q, wsum_d;
    logic [31:0]      rsum_q, rsum_d;
    logic [31:0]      idle_q, idle_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             core_hold_q, core_hold_d;

    logic             in_load;
    logic             accept;
    logic             can_start;
    logic             count_bad;
    logic             last_load;
    logic             last_read;
    logic             unused_base_lo;

    // Byte offset of word index idx; the add into base wraps mod 2^32.
    function automatic logic [31:0] word_off(input logic [CNT_W-1:0] idx);
        logic [31:0] w;
        w = 32'(idx);
        return w << 2;
    endfunction

    assign unused_base_lo = ^base_addr[1:0];

    assign in_load   = (state_q == S_LOAD);
    assign accept    = in_load && s_valid;
    assign can_start = (state_q == S_IDLE) || (state_q == S_DONE) ||
                       (state_q == S_ERROR);
    assign count_bad = (word_count == '0) ||
                       (32'(word_count) > 32'(MAX_WORDS));
    assign last_load = ((load_count_q + CNT_ONE) == count_q);
    assign last_read = ((vcount_q + CNT_ONE) == count_q);

    assign s_ready    = in_load;
    assign busy       = in_load || (state_q == S_RD_ISSUE) ||
                        (state_q == S_RD_CHECK) || (state_q == S_COMPARE);
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_code_q;
    assign core_hold  = core_hold_q;
    assign load_count = load_count_q;

    // Writes are combinational so the memory captures the word on the
    // same edge the stream handshake completes.
    always_comb begin
        dbg_en    = 1'b0;
        dbg_we    = 1'b0;
        dbg_addr  = '0;
        dbg_wdata = '0;
        if (accept) begin
            dbg_en    = 1'b1;
            dbg_we    = 1'b1;
            dbg_addr  = base_q + word_off(load_count_q);
            dbg_wdata = s_data;
        end else if (state_q == S_RD_ISSUE) begin
            dbg_en   = 1'b1;
            dbg_addr = base_q + word_off(vcount_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        count_d      = count_q;
        verify_d     = verify_q;
        load_count_d = load_count_q;
        vcount_d     = vcount_q;
        wsum_d       = wsum_q;
        rsum_d       = rsum_q;
        idle_d       = idle_q;
        done_d       = done_q;
        error_d      = error_q;
        err_code_d   = err_code_q;
        core_hold_d  = core_hold_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start && can_start) begin
                    base_d       = {base_addr[31:2], 2'b00};
                    count_d      = word_count;
                    verify_d     = verify_en;
                    load_count_d = '0;
                    vcount_d     = '0;
                    wsum_d       = '0;
                    rsum_d       = '0;
                    idle_d       = '0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    err_code_d   = E_NONE;
                    core_hold_d  = 1'b1;
                    if (count_bad) begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = E_COUNT;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (s_valid) begin
                    load_count_d = load_count_q + CNT_ONE;
                    wsum_d       = wsum_q + s_data;
                    idle_d       = '0;
                    if (last_load) begin
                        if (verify_q) begin
                            state_d = S_RD_ISSUE;
                        end else begin
                            state_d     = S_DONE;
                            done_d      = 1'b1;
                            core_hold_d = 1'b0;
                        end
                    end
                end else if (TIMEOUT != 0) begin
                    idle_d = idle_q + 32'd1;
                    if (idle_d == TIMEOUT) begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = E_TIMEOUT;
                    end
                end
            end
            S_RD_ISSUE: begin
                state_d = S_RD_CHECK;
            end
            S_RD_CHECK: begin
                rsum_d   = rsum_q + dbg_rdata;
                vcount_d = vcount_q + CNT_ONE;
                state_d  = last_read ? S_COMPARE : S_RD_ISSUE;
            end
            S_COMPARE: begin
                if (rsum_q == wsum_q) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    core_hold_d = 1'b0;
                end else begin
                    state_d    = S_ERROR;
                    error_d    = 1'b1;
                    err_code_d = E_VERIFY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            state_d     = S_IDLE;
            core_hold_d = 1'b1;
            done_d      = 1'b0;
            error_d     = 1'b0;
            err_code_d  = E_NONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            count_q      <= '0;
            verify_q     <= 1'b0;
            load_count_q <= '0;
            vcount_q     <= '0;
            wsum_q       <= '0;
            rsum_q       <= '0;
            idle_q       <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= E_NONE;
            core_hold_q  <= HOLD_ON_RESET;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            count_q      <= count_d;
            verify_q     <= verify_d;
            load_count_q <= load_count_d;
            vcount_q     <= vcount_d;
            wsum_q       <= wsum_d;
            rsum_q       <= rsum_d;
            idle_q       <= idle_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            core_hold_q  <= core_hold_d;
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Testbench for imem_program_loader: table-driven loads, randomized loads
// against a checksum/address reference model, and hand-written corner cases.
module tb_imem_program_loader;

    localparam int CNT_W = 16;
    localparam int MAXW  = 1024;
    localparam int TMO   = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [31:0]      base_addr = '0;
    logic [CNT_W-1:0] word_count = '0;
    logic             verify_en = 1'b0;
    logic             s_valid = 1'b0;
    logic [31:0]      s_data = '0;
    logic             s_ready;
    logic             dbg_en;
    logic             dbg_we;
    logic [31:0]      dbg_addr;
    logic [31:0]      dbg_wdata;
    logic [31:0]      dbg_rdata = '0;
    logic             core_hold;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] load_count;

    always #5 clk = ~clk;

    imem_program_loader #(
        .CNT_W(CNT_W),
        .MAX_WORDS(MAXW),
        .TIMEOUT(TMO),
        .HOLD_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .base_addr(base_addr),
        .word_count(word_count),
        .verify_en(verify_en),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .dbg_en(dbg_en),
        .dbg_we(dbg_we),
        .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata),
        .core_hold(core_hold),
        .busy(busy),
        .done(done),
        .error(error),
        .err_code(err_code),
        .load_count(load_count)
    );

    // Behavioural instruction memory plus access logs.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] rd_addr_q[$];
    int          dbg_cycles = 0;
    int          busy_cycles = 0;
    logic        corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = '0;

    always @(posedge clk) begin
        if (!reset) begin
            if (dbg_en) dbg_cycles++;
            if (busy) busy_cycles++;
            if (dbg_en && dbg_we) begin
                mem[dbg_addr] = dbg_wdata;
                wr_addr_q.push_back(dbg_addr);
                wr_data_q.push_back(dbg_wdata);
            end
            if (dbg_en && !dbg_we) begin
                rd_addr_q.push_back(dbg_addr);
                if (corrupt_en && dbg_addr == corrupt_addr)
                    dbg_rdata <= 32'hDEADBEEF;
                else if (mem.exists(dbg_addr))
                    dbg_rdata <= mem[dbg_addr];
                else
                    dbg_rdata <= '0;
            end
        end
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outcome from the rules: illegal length -> 1; with verify,
    // the sum of what memory returns must equal the sum of what was sent.
    function automatic logic [1:0] model_code(input int cnt, input bit ver,
                                              input int bad,
                                              input logic [31:0] data[$]);
        logic [31:0] ws;
        logic [31:0] rs;
        if (cnt == 0 || cnt > MAXW) return 2'd1;
        if (!ver) return 2'd0;
        ws = 0;
        rs = 0;
        foreach (data[i]) begin
            ws += data[i];
            rs += (i == bad) ? 32'hDEADBEEF : data[i];
        end
        return (ws == rs) ? 2'd0 : 2'd2;
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic run_load(input string tag, input logic [31:0] base,
                            input int cnt, input bit ver, input int bad,
                            input int maxgap, input logic [31:0] data[$],
                            input logic [1:0] exp_code);
        logic [31:0] ab;
        int w0, r0, d0, b0, gaps, t, g, werr, rerr, nw, nr;
        bit legal, rdy_ok;
        ab = {base[31:2], 2'b00};
        legal = (cnt > 0) && (cnt <= MAXW);
        w0 = wr_addr_q.size();
        r0 = rd_addr_q.size();
        d0 = dbg_cycles;
        b0 = busy_cycles;
        gaps = 0;
        rdy_ok = 1'b1;
        corrupt_en = (bad >= 0);
        corrupt_addr = ab + 32'(bad) * 4;
        start = 1'b1;
        base_addr = base;
        word_count = cnt[CNT_W-1:0];
        verify_en = ver;
        @(negedge clk);
        start = 1'b0;
        if (legal) begin
            for (int i = 0; i < cnt; i++) begin
                g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
                for (int k = 0; k < g; k++) begin
                    s_valid = 1'b0;
                    @(negedge clk);
                    gaps++;
                end
                s_valid = 1'b1;
                s_data = data[i];
                if (!s_ready) rdy_ok = 1'b0;
                @(negedge clk);
            end
        end
        s_valid = 1'b0;
        t = 0;
        while (!(done || error) && t < 3 * cnt + 40) begin
            @(negedge clk);
            t++;
        end
        check({tag, ".ready"}, 32'(rdy_ok), 1);
        check({tag, ".finished"}, 32'(done || error), 1);
        check({tag, ".done"}, 32'(done), 32'(exp_code == 0));
        check({tag, ".error"}, 32'(error), 32'(exp_code != 0));
        check({tag, ".err_code"}, 32'(err_code), 32'(exp_code));
        check({tag, ".core_hold"}, 32'(core_hold), 32'(exp_code != 0));
        check({tag, ".load_count"}, 32'(load_count), legal ? cnt : 0);
        nw = wr_addr_q.size() - w0;
        nr = rd_addr_q.size() - r0;
        check({tag, ".n_writes"}, nw, legal ? cnt : 0);
        check({tag, ".n_reads"}, nr, (legal && ver) ? cnt : 0);
        werr = 0;
        rerr = 0;
        for (int i = 0; i < nw && i < cnt; i++) begin
            if (wr_addr_q[w0+i] !== ab + 32'(i) * 4) werr++;
            if (wr_data_q[w0+i] !== data[i]) werr++;
        end
        for (int i = 0; i < nr && i < cnt; i++)
            if (rd_addr_q[r0+i] !== ab + 32'(i) * 4) rerr++;
        check({tag, ".wr_match"}, werr, 0);
        check({tag, ".rd_match"}, rerr, 0);
        check({tag, ".dbg_cycles"}, dbg_cycles - d0,
              legal ? cnt * (ver ? 2 : 1) : 0);
        check({tag, ".busy_cycles"}, busy_cycles - b0,
              legal ? cnt + gaps + (ver ? 2 * cnt + 1 : 0) : 0);
        corrupt_en = 1'b0;
    endtask

    typedef struct {
        logic [31:0] base;
        int          cnt;
        bit          ver;
        int          bad;
        int          gap;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t        tv[8];
    logic [31:0] prog[$];
    logic [31:0] dq[$];

    initial begin
        int cnt, bad, gap;
        bit ver;
        logic [31:0] base;
        logic [1:0] code;
        int t, nw;

        prog = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013};
        tv[0] = '{32'h0000_0000, 4, 1'b0, -1, 0, 2'd0};
        tv[1] = '{32'h0000_0000, 4, 1'b1, -1, 0, 2'd0};
        tv[2] = '{32'h0000_0000, 4, 1'b1, 2, 0, 2'd2};
        tv[3] = '{32'h0000_0000, 0, 1'b0, -1, 0, 2'd1};
        tv[4] = '{32'h0000_0000, MAXW + 1, 1'b1, -1, 0, 2'd1};
        tv[5] = '{32'hFFFF_FFF8, 4, 1'b1, -1, 2, 2'd0};
        tv[6] = '{32'h0000_0103, 5, 1'b0, -1, 3, 2'd0};
        tv[7] = '{32'h0000_1000, MAXW, 1'b0, -1, 0, 2'd0};

        repeat (3) @(negedge clk);
        check("rst.done", done, 0);
        check("rst.error", error, 0);
        check("rst.busy", busy, 0);
        check("rst.s_ready", s_ready, 0);
        check("rst.dbg_en", dbg_en, 0);
        check("rst.err_code", err_code, 0);
        check("rst.load_count", load_count, 0);
        check("rst.core_hold", core_hold, 1);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            dq.delete();
            if (v < 3) dq = prog;
            else if (tv[v].cnt <= MAXW)
                for (int i = 0; i < tv[v].cnt; i++) dq.push_back($urandom);
            run_load($sformatf("tv%0d", v), tv[v].base, tv[v].cnt, tv[v].ver,
                     tv[v].bad, tv[v].gap, dq, tv[v].exp_code);
        end

        for (int r = 0; r < 12; r++) begin
            cnt = $urandom_range(0, 24);
            base = $urandom;
            ver = 1'($urandom_range(0, 1));
            bad = ($urandom_range(0, 2) == 0 && cnt > 0) ?
                  $urandom_range(0, cnt - 1) : -1;
            gap = $urandom_range(0, 4);
            dq.delete();
            for (int i = 0; i < cnt; i++) dq.push_back($urandom);
            code = model_code(cnt, ver, bad, dq);
            run_load($sformatf("rnd%0d", r), base, cnt, ver, bad, gap, dq,
                     code);
        end

        // Timeout: two words then silence.
        start = 1'b1;
        base_addr = 32'h100;
        word_count = 4;
        verify_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_data = $urandom;
            @(negedge clk);
        end
        s_valid = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        check("tmo.early", error, 0);
        @(negedge clk);
        check("tmo.error", error, 1);
        check("tmo.err_code", err_code, 3);
        check("tmo.load_count", load_count, 2);
        check("tmo.core_hold", core_hold, 1);
        check("tmo.last_addr", wr_addr_q[$], 32'h104);

        // Abort mid-load, with a word presented in the abort cycle.
        start = 1'b1;
        base_addr = 32'h0;
        word_count = 4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_data = $urandom;
            @(negedge clk);
        end
        nw = wr_addr_q.size();
        s_valid = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        s_valid = 1'b0;
        check("abort.write", wr_addr_q.size() - nw, 1);
        check("abort.write_addr", wr_addr_q[$], 32'h8);
        check("abort.busy", busy, 0);
        check("abort.core_hold", core_hold, 1);
        check("abort.done", done, 0);
        start = 1'b1;
        base_addr = 32'h40;
        word_count = 3;
        @(negedge clk);
        start = 1'b0;
        check("reload.lc_restart", load_count, 0);
        check("reload.busy", busy, 1);
        nw = wr_addr_q.size();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data = $urandom;
            @(negedge clk);
        end
        s_valid = 1'b0;
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("reload.done", done, 1);
        check("reload.load_count", load_count, 3);
        check("reload.first_addr", wr_addr_q[nw], 32'h40);
        check("reload.last_addr", wr_addr_q[$], 32'h48);

        // abort and start together from DONE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        word_count = 4;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abst.busy", busy, 0);
        check("abst.done", done, 0);
        check("abst.core_hold", core_hold, 1);

        // Reset while in RD_CHECK.
        start = 1'b1;
        base_addr = 32'h0;
        word_count = 4;
        verify_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data = prog[i];
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("rdchk.issue", {dbg_en, dbg_we}, 2'b10);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rrst.done", done, 0);
        check("rrst.error", error, 0);
        check("rrst.busy", busy, 0);
        check("rrst.s_ready", s_ready, 0);
        check("rrst.dbg", {dbg_en, dbg_we, dbg_addr, dbg_wdata}, 0);
        check("rrst.err_code", err_code, 0);
        check("rrst.load_count", load_count, 0);
        check("rrst.core_hold", core_hold, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rrst.idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
